// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// mips_pkg : shared types and constants for the instruction-memory loader
// Rev 1.0  : initial release
// ============================================================================
package mips_pkg;

   localparam int WORD_W         = 32;
   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HDR  = 3'd1,
      DATA = 3'd2,
      CHK  = 3'd3,
      DONE = 3'd4,
      ERR  = 3'd5
   } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/imem_word_packer.sv
`default_nettype none
// ============================================================================
// imem_word_packer : packs little-endian bytes into words (byte0 = word[7:0])
// Rev 1.0          : initial release
// ============================================================================
module imem_word_packer
   import mips_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              in_valid,
   input  logic [7:0]        in_byte,
   output logic              word_valid,
   output logic [WORD_W-1:0] word
);

   localparam int SR_W = (BYTES_PER_WORD - 1) * 8;

   logic [1:0]      byte_cnt;
   logic [SR_W-1:0] shift_reg;

   // The completing byte is merged combinationally so the loader can register
   // the memory write on the same edge as the final handshake.
   assign word_valid = in_valid && (byte_cnt == 2'(BYTES_PER_WORD - 1));
   assign word       = {in_byte, shift_reg};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         byte_cnt  <= '0;
         shift_reg <= '0;
      end else if (clear) begin
         byte_cnt  <= '0;
      end else if (in_valid) begin
         shift_reg <= {in_byte, shift_reg[SR_W-1:8]};
         byte_cnt  <= byte_cnt + 2'd1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// imem_loader : streams a counted program into instruction memory, holding the
//               core in reset meanwhile. Option macro: LOADER_CHECKSUM_EN.
// Rev 1.0     : initial release
// ============================================================================
module imem_loader
   import mips_pkg::*;
#(
   parameter int ADDR_W = 8
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              load_req,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [WORD_W-1:0] imem_wdata,
   output logic              core_hold,
   output logic              done,
   output logic              error
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

`ifdef LOADER_CHECKSUM_EN
   localparam loader_state_t END_STATE = CHK;
   localparam logic          END_READY = 1'b1;
`else
   localparam loader_state_t END_STATE = DONE;
   localparam logic          END_READY = 1'b0;
`endif

   loader_state_t     state;
   logic [7:0]        hdr_lo;
   logic              hdr_hi;
   logic [15:0]       word_cnt;
   logic [15:0]       word_idx;
   logic [15:0]       hdr_n;
   logic              fire;
   logic              start;
   logic              word_valid;
   logic [WORD_W-1:0] word;

   assign fire  = byte_valid && byte_ready;
   assign start = load_req && ((state == IDLE) || (state == ERR));
   assign hdr_n = {byte_data, hdr_lo};

   imem_word_packer u_packer (
      .clk        (clk),
      .reset      (reset),
      .clear      (start),
      .in_valid   (fire && (state == DATA)),
      .in_byte    (byte_data),
      .word_valid (word_valid),
      .word       (word)
   );

`ifdef LOADER_CHECKSUM_EN
   logic [7:0] csum;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         csum <= '0;
      end else if (start) begin
         csum <= '0;
      end else if (fire && ((state == HDR) || (state == DATA))) begin
         csum <= csum ^ byte_data;
      end
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         byte_ready <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         core_hold  <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         hdr_lo     <= '0;
         hdr_hi     <= 1'b0;
         word_cnt   <= '0;
         word_idx   <= '0;
      end else begin
         imem_we <= 1'b0;
         done    <= 1'b0;
         case (state)
            IDLE, ERR: begin
               if (load_req) begin
                  state      <= HDR;
                  byte_ready <= 1'b1;
                  core_hold  <= 1'b1;
                  error      <= 1'b0;
                  imem_addr  <= '0;
                  hdr_hi     <= 1'b0;
                  word_idx   <= '0;
               end
            end
            HDR: begin
               if (fire) begin
                  if (!hdr_hi) begin
                     hdr_lo <= byte_data;
                     hdr_hi <= 1'b1;
                  end else if ({16'd0, hdr_n} > DEPTH) begin
                     state      <= ERR;
                     error      <= 1'b1;
                     byte_ready <= 1'b0;
                  end else if (hdr_n == 16'd0) begin
                     state      <= END_STATE;
                     byte_ready <= END_READY;
                     done       <= !END_READY;
                  end else begin
                     state    <= DATA;
                     word_cnt <= hdr_n;
                  end
               end
            end
            DATA: begin
               if (word_valid) begin
                  imem_we    <= 1'b1;
                  imem_addr  <= ADDR_W'(word_idx);
                  imem_wdata <= word;
                  word_idx   <= word_idx + 16'd1;
                  if (word_idx == word_cnt - 16'd1) begin
                     state      <= END_STATE;
                     byte_ready <= END_READY;
                     done       <= !END_READY;
                  end
               end
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
               if (fire) begin
                  byte_ready <= 1'b0;
                  if (byte_data == csum) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= ERR;
                     error <= 1'b1;
                  end
               end
            end
`endif
            DONE: begin
               state     <= IDLE;
               core_hold <= 1'b0;
            end
            default: begin
               state      <= IDLE;
               byte_ready <= 1'b0;
               core_hold  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// tb_imem_loader : randomized and directed bench for imem_loader (ADDR_W=2)
// Rev 1.0        : initial release
// ============================================================================
module tb_imem_loader;

   localparam int ADDR_W = 2;
   localparam int DEPTH  = 1 << ADDR_W;
`ifdef LOADER_CHECKSUM_EN
   localparam int CHKB = 1;
`else
   localparam int CHKB = 0;
`endif

   typedef logic [7:0] bq_t[$];

   logic              clk        = 1'b0;
   logic              reset      = 1'b1;
   logic              load_req   = 1'b0;
   logic              byte_valid = 1'b0;
   logic [7:0]        byte_data  = 8'h00;
   logic              byte_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              core_hold;
   logic              done;
   logic              error;

   int checks = 0;
   int errors = 0;
   bit chk_on = 1'b0;
   logic [ADDR_W+31:0] wq[$];
   int dcount = 0;

   // Reference model: outputs expected during the cycle after each edge
   logic              m_ready = 1'b0;
   logic              m_we    = 1'b0;
   logic              m_hold  = 1'b0;
   logic              m_done  = 1'b0;
   logic              m_err   = 1'b0;
   logic [ADDR_W-1:0] m_addr  = '0;
   logic [31:0]       m_wdata = '0;
   int                m_cnt   = 0;
   int                m_n     = 0;
   logic [7:0]        mb [0:63];

   imem_loader #(.ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .load_req   (load_req),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_hold  (core_hold),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Stream rules: byte k of the accepted stream lands in mb[k]; bytes 0,1 are N,
   // bytes 2+4w..5+4w form word w, optional final byte is XOR of everything before.
   always @(posedge clk) begin : p_model
      automatic int idx;
      automatic int n;
      automatic int tot;
      automatic logic [7:0] x;
      if (reset) begin
         m_ready <= 1'b0; m_we <= 1'b0; m_hold <= 1'b0; m_done <= 1'b0; m_err <= 1'b0;
         m_addr <= '0; m_wdata <= '0; m_cnt <= 0; m_n <= 0;
      end else begin
         m_we   <= 1'b0;
         m_done <= 1'b0;
         if (m_done) m_hold <= 1'b0;
         if (load_req && (!m_hold || m_err)) begin
            m_hold <= 1'b1; m_err <= 1'b0; m_ready <= 1'b1; m_cnt <= 0;
         end else if (byte_valid && m_ready) begin
            idx = m_cnt;
            mb[idx] <= byte_data;
            m_cnt <= idx + 1;
            n   = (idx == 1) ? int'({byte_data, mb[0]}) : m_n;
            tot = 2 + 4 * n + CHKB;
            if (idx == 1) m_n <= n;
            if (idx == 1 && n > DEPTH) begin
               m_err <= 1'b1; m_ready <= 1'b0;
            end else if (idx + 1 == tot) begin
               x = 8'h00;
               for (int k = 0; k < idx; k++) x ^= mb[k];
               m_ready <= 1'b0;
               if (CHKB == 1 && byte_data != x) m_err <= 1'b1;
               else m_done <= 1'b1;
            end
            if (idx >= 2 && idx < 2 + 4 * n && (idx - 2) % 4 == 3) begin
               m_we    <= 1'b1;
               m_addr  <= ADDR_W'((idx - 2) / 4);
               m_wdata <= {byte_data, mb[idx-1], mb[idx-2], mb[idx-3]};
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on && !reset) begin
         chk("byte_ready", byte_ready, m_ready);
         chk("core_hold", core_hold, m_hold);
         chk("done", done, m_done);
         chk("error", error, m_err);
         chk("imem_we", imem_we, m_we);
         if (m_we) begin
            chk("imem_addr", imem_addr, m_addr);
            chk("imem_wdata", imem_wdata, m_wdata);
         end
         if (imem_we) wq.push_back({imem_addr, imem_wdata});
         if (done) dcount++;
      end
   end

   function automatic bq_t with_csum(input bq_t s);
      logic [7:0] x = 8'h00;
      foreach (s[i]) x ^= s[i];
      if (CHKB == 1) s.push_back(x);
      return s;
   endfunction

   task automatic pulse_load();
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int maxgap);
      automatic int t = 0;
      repeat ($urandom_range(0, maxgap)) @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = b;
      while (!byte_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) begin
         chk("handshake_timeout", byte_ready, 1);
         byte_valid = 1'b0;
         return;
      end
      @(negedge clk);
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
   endtask

   task automatic send_stream(input bq_t s, input int maxgap);
      foreach (s[i]) send_byte(s[i], maxgap);
   endtask

   task automatic wait_done();
      automatic int t = 0;
      while (!done && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("done_seen", done, 1);
      @(negedge clk);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got no completion expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bq_t q;
      int  n;
      @(negedge clk);
      chk("rst_ready", byte_ready, 0);
      chk("rst_we", imem_we, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_wdata", imem_wdata, 0);
      chk("rst_hold", core_hold, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      @(negedge clk);
      reset  = 1'b0;
      chk_on = 1'b1;
      @(negedge clk);

      // Basic two-word load with latency pinned at the first write
      wq.delete(); dcount = 0;
      pulse_load();
      chk("hold_after_req", core_hold, 1);
      q = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      q = with_csum(q);
      for (int i = 0; i < 6; i++) send_byte(q[i], 0);
      chk("lat_we", imem_we, 1);
      chk("lat_data", imem_wdata, 32'h12345678);
      for (int i = 6; i < q.size(); i++) send_byte(q[i], 0);
      wait_done();
      #1;
      chk("basic_nwrites", wq.size(), 2);
      chk("basic_w0", wq[0], {2'd0, 32'h12345678});
      chk("basic_w1", wq[1], {2'd1, 32'hDEADBEEF});
      chk("basic_done", dcount, 1);
      chk("basic_hold_released", core_hold, 0);

      // Same stream with idle gaps
      wq.delete(); dcount = 0;
      @(negedge clk);
      pulse_load();
      send_stream(q, 3);
      wait_done();
      #1;
      chk("gap_nwrites", wq.size(), 2);
      chk("gap_w1", wq[1], {2'd1, 32'hDEADBEEF});

      // Empty program
      wq.delete(); dcount = 0;
      @(negedge clk);
      pulse_load();
      q = '{8'h00, 8'h00};
      send_stream(with_csum(q), 0);
      chk("n0_done", done, 1);
      wait_done();
      #1;
      chk("n0_nwrites", wq.size(), 0);

      // Oversized header, then recovery
      wq.delete(); dcount = 0;
      @(negedge clk);
      pulse_load();
      q = '{8'h05, 8'h00};
      send_stream(q, 1);
      chk("big_error", error, 1);
      repeat (3) @(negedge clk);
      #1;
      chk("big_error_sticky", error, 1);
      chk("big_ready", byte_ready, 0);
      chk("big_hold", core_hold, 1);
      chk("big_nwrites", wq.size(), 0);
      @(negedge clk);
      pulse_load();
      chk("big_error_cleared", error, 0);
      q = '{8'h04, 8'h00};
      for (int i = 0; i < 16; i++) q.push_back(8'($urandom));
      send_stream(with_csum(q), 2);
      wait_done();

      // Randomized loads, including oversized headers
      for (int r = 0; r < 40; r++) begin
         n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(DEPTH + 1, 65535)) : int'($urandom_range(0, DEPTH));
         q = '{8'(n), 8'(n >> 8)};
         @(negedge clk);
         pulse_load();
         if (n > DEPTH) begin
            send_stream(q, 3);
            repeat (2) @(negedge clk);
         end else begin
            for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
            send_stream(with_csum(q), 3);
            wait_done();
         end
      end

      // Reset in the middle of a load
      @(negedge clk);
      pulse_load();
      q = '{8'h02, 8'h00, 8'hAB, 8'hCD};
      send_stream(q, 0);
      reset = 1'b1;
      #1;
      chk("midrst_hold", core_hold, 0);
      chk("midrst_ready", byte_ready, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Fresh load with a stray load_req pulse mid-stream
      wq.delete(); dcount = 0;
      pulse_load();
      q = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
      q = with_csum(q);
      for (int i = 0; i < 3; i++) send_byte(q[i], 0);
      pulse_load();
      for (int i = 3; i < q.size(); i++) send_byte(q[i], 1);
      wait_done();
      #1;
      chk("fresh_nwrites", wq.size(), 1);
      chk("fresh_w0", wq[0], {2'd0, 32'h44332211});
      chk("fresh_done", dcount, 1);

`ifdef LOADER_CHECKSUM_EN
      // Bad checksum: word written, error, no done
      wq.delete(); dcount = 0;
      @(negedge clk);
      pulse_load();
      q = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
      send_stream(q, 0);
      repeat (2) @(negedge clk);
      #1;
      chk("csum_bad_error", error, 1);
      chk("csum_bad_nwrites", wq.size(), 1);
      chk("csum_bad_done", dcount, 0);
      @(negedge clk);
      wq.delete(); dcount = 0;
      pulse_load();
      q = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01};
      send_stream(q, 0);
      wait_done();
      #1;
      chk("csum_good_done", dcount, 1);
      chk("csum_good_w0", wq[0], {2'd0, 32'hDDCCBBAA});
`endif

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
